rtc_acceso_arbitro: RTL and testbench

RTC_ACCESO_ARBITRO -- requirements
Module: rtc_acceso_arbitro

---
 rtl/rtc_acceso_arbitro.sv | 201 ++++++++++++++++++++
 tb/tb_rtc_acceso_arbitro.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rtc_acceso_arbitro.sv
// rtl/rtc_acceso_arbitro.sv - Arbitrates init/write/read RTC bursts onto a single bus engine.
// Optional WAIT timeout with err flag when RTC_TIMEOUT_EN is defined.
module rtc_acceso_arbitro (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_init,
  input  logic       req_esc,
  input  logic       req_lee,
  input  logic       clk_timer,
  input  logic [7:0] dato_seg,
  input  logic [7:0] dato_min,
  input  logic [7:0] dato_hora,
  output logic       tx_start,
  output logic       tx_wr,
  output logic [7:0] tx_dir,
  output logic [7:0] tx_dato,
  input  logic       tx_done,
  input  logic [7:0] tx_rdata,
  output logic       ack_init,
  output logic       ack_esc,
  output logic       ack_lee,
  output logic [7:0] rd_seg,
  output logic [7:0] rd_min,
  output logic [7:0] rd_hora,
  output logic       ocupado,
  output logic       err
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_DONE} state_t;
  typedef enum logic [1:0] {BT_INIT, BT_ESC, BT_LEE} burst_t;

  state_t     state_q, state_d;
  burst_t     burst_q, burst_d;
  logic [1:0] idx_q, idx_d;
  logic       bank_q, bank_d;
  logic [7:0] dseg_q, dseg_d, dmin_q, dmin_d, dhora_q, dhora_d;
  logic [7:0] sh_seg_q, sh_seg_d, sh_min_q, sh_min_d, sh_hora_q, sh_hora_d;
  logic [7:0] rd_seg_q, rd_seg_d, rd_min_q, rd_min_d, rd_hora_q, rd_hora_d;
  logic       timed_out;
`ifdef RTC_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
  assign timed_out = err_q;
  assign err       = err_q;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    idx_d     = idx_q;
    bank_d    = bank_q;
    dseg_d    = dseg_q;
    dmin_d    = dmin_q;
    dhora_d   = dhora_q;
    sh_seg_d  = sh_seg_q;
    sh_min_d  = sh_min_q;
    sh_hora_d = sh_hora_q;
    rd_seg_d  = rd_seg_q;
    rd_min_d  = rd_min_q;
    rd_hora_d = rd_hora_q;
`ifdef RTC_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_init || req_esc || req_lee) begin
          state_d = ST_START;
          idx_d   = 2'd0;
          burst_d = req_init ? BT_INIT : (req_esc ? BT_ESC : BT_LEE);
          bank_d  = clk_timer;
          dseg_d  = dato_seg;
          dmin_d  = dato_min;
          dhora_d = dato_hora;
`ifdef RTC_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef RTC_TIMEOUT_EN
        tmo_d   = 8'd0;
`endif
      end
      ST_WAIT: begin
        if (tx_done) begin
          if (burst_q == BT_LEE) begin
            case (idx_q)
              2'd0:    sh_seg_d  = tx_rdata;
              2'd1:    sh_min_d  = tx_rdata;
              default: sh_hora_d = tx_rdata;
            endcase
          end
          if (idx_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_START;
          end
        end
`ifdef RTC_TIMEOUT_EN
        // 255th consecutive WAIT cycle without completion abandons the burst
        else if (tmo_q == 8'd254) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: begin
        if (burst_q == BT_LEE && !timed_out) begin
          rd_seg_d  = sh_seg_q;
          rd_min_d  = sh_min_q;
          rd_hora_d = sh_hora_q;
        end
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      burst_q   <= BT_INIT;
      idx_q     <= 2'd0;
      bank_q    <= 1'b0;
      dseg_q    <= 8'd0;
      dmin_q    <= 8'd0;
      dhora_q   <= 8'd0;
      sh_seg_q  <= 8'd0;
      sh_min_q  <= 8'd0;
      sh_hora_q <= 8'd0;
      rd_seg_q  <= 8'd0;
      rd_min_q  <= 8'd0;
      rd_hora_q <= 8'd0;
`ifdef RTC_TIMEOUT_EN
      tmo_q     <= 8'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      idx_q     <= idx_d;
      bank_q    <= bank_d;
      dseg_q    <= dseg_d;
      dmin_q    <= dmin_d;
      dhora_q   <= dhora_d;
      sh_seg_q  <= sh_seg_d;
      sh_min_q  <= sh_min_d;
      sh_hora_q <= sh_hora_d;
      rd_seg_q  <= rd_seg_d;
      rd_min_q  <= rd_min_d;
      rd_hora_q <= rd_hora_d;
`ifdef RTC_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  logic [7:0] step_dato, init_dir, init_dato, bank_dir;

  always_comb begin
    case (idx_q)
      2'd0:    begin step_dato = dseg_q;  init_dir = 8'h02; init_dato = 8'h10; end
      2'd1:    begin step_dato = dmin_q;  init_dir = 8'h00; init_dato = 8'hD2; end
      default: begin step_dato = dhora_q; init_dir = 8'h10; init_dato = 8'h00; end
    endcase
    bank_dir = (bank_q ? 8'h20 : 8'h40) | {6'd0, idx_q + 2'd1};
  end

  // Bus request fields are pure functions of latched state, so they hold through WAIT
  always_comb begin
    tx_start = (state_q == ST_START);
    tx_wr    = 1'b0;
    tx_dir   = 8'h00;
    tx_dato  = 8'h00;
    if (state_q == ST_START || state_q == ST_WAIT) begin
      case (burst_q)
        BT_INIT: begin tx_wr = 1'b1; tx_dir = init_dir; tx_dato = init_dato; end
        BT_ESC:  begin tx_wr = 1'b1; tx_dir = bank_dir; tx_dato = step_dato; end
        default: begin tx_dir = bank_dir; end
      endcase
    end
  end

  assign ack_init = (state_q == ST_DONE) && (burst_q == BT_INIT);
  assign ack_esc  = (state_q == ST_DONE) && (burst_q == BT_ESC);
  assign ack_lee  = (state_q == ST_DONE) && (burst_q == BT_LEE);
  assign ocupado  = (state_q != ST_IDLE);
  assign rd_seg   = rd_seg_q;
  assign rd_min   = rd_min_q;
  assign rd_hora  = rd_hora_q;

endmodule

// File: tb/tb_rtc_acceso_arbitro.sv
// tb/tb_rtc_acceso_arbitro.sv - Directed vector table plus hand sequences for rtc_acceso_arbitro.
module tb_rtc_acceso_arbitro;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_init = 1'b0, req_esc = 1'b0, req_lee = 1'b0, clk_timer = 1'b0;
  logic [7:0] dato_seg = 8'd0, dato_min = 8'd0, dato_hora = 8'd0;
  logic       tx_start, tx_wr;
  logic [7:0] tx_dir, tx_dato;
  logic       tx_done = 1'b0;
  logic [7:0] tx_rdata = 8'd0;
  logic       ack_init, ack_esc, ack_lee, ocupado, err;
  logic [7:0] rd_seg, rd_min, rd_hora;

  int checks = 0;
  int failures = 0;

  rtc_acceso_arbitro dut (
    .clk(clk), .reset(reset),
    .req_init(req_init), .req_esc(req_esc), .req_lee(req_lee), .clk_timer(clk_timer),
    .dato_seg(dato_seg), .dato_min(dato_min), .dato_hora(dato_hora),
    .tx_start(tx_start), .tx_wr(tx_wr), .tx_dir(tx_dir), .tx_dato(tx_dato),
    .tx_done(tx_done), .tx_rdata(tx_rdata),
    .ack_init(ack_init), .ack_esc(ack_esc), .ack_lee(ack_lee),
    .rd_seg(rd_seg), .rd_min(rd_min), .rd_hora(rd_hora),
    .ocupado(ocupado), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ri, re, rl, ct, done;
    logic [7:0]  rdata;
    logic [23:0] din;
    logic        e_start, e_wr;
    logic [7:0]  e_dir, e_dato;
    logic [2:0]  e_ack;
    logic        e_oc;
    logic [23:0] e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ri, re, rl, ct, done, input logic [7:0] rdata,
                     input logic [23:0] din, input logic e_start, e_wr,
                     input logic [7:0] e_dir, e_dato, input logic [2:0] e_ack,
                     input logic e_oc, input logic [23:0] e_rd);
    vec_t v;
    v.ri = ri; v.re = re; v.rl = rl; v.ct = ct; v.done = done; v.rdata = rdata; v.din = din;
    v.e_start = e_start; v.e_wr = e_wr; v.e_dir = e_dir; v.e_dato = e_dato;
    v.e_ack = e_ack; v.e_oc = e_oc; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [45:0] obs();
    return {tx_start, tx_wr, tx_dir, tx_dato, ack_init, ack_esc, ack_lee, ocupado,
            rd_seg, rd_min, rd_hora};
  endfunction

  localparam logic [23:0] RD1 = 24'h453012;

  int   order[3];
  int   cyc[3];
  int   nack;
  logic prev_start;
  logic bad;
  int   n;

  initial begin
    // read burst, clock bank; clk_timer changed after grant must be ignored
    add(0,0,1,1,0,8'h00,0, 1,0,8'h21,8'h00,3'b000,1,24'h0);
    add(0,0,0,1,0,8'h00,0, 0,0,8'h21,8'h00,3'b000,1,24'h0);
    add(0,0,0,0,1,8'h45,0, 1,0,8'h22,8'h00,3'b000,1,24'h0);
    add(0,0,0,0,0,8'h00,0, 0,0,8'h22,8'h00,3'b000,1,24'h0);
    add(0,0,0,0,1,8'h30,0, 1,0,8'h23,8'h00,3'b000,1,24'h0);
    add(0,0,0,0,0,8'h00,0, 0,0,8'h23,8'h00,3'b000,1,24'h0);
    add(0,0,0,0,1,8'h12,0, 0,0,8'h00,8'h00,3'b001,1,24'h0);
    add(0,0,0,0,1,8'h99,0, 0,0,8'h00,8'h00,3'b000,0,RD1);
    add(0,0,0,0,1,8'h55,0, 0,0,8'h00,8'h00,3'b000,0,RD1);
    // write burst, timer bank; stray tx_done at grant and in START; data changed after grant
    add(0,1,0,0,1,8'h00,24'h030405, 1,1,8'h41,8'h05,3'b000,1,RD1);
    add(0,1,0,1,1,8'h00,24'hFFFFFF, 0,1,8'h41,8'h05,3'b000,1,RD1);
    add(0,1,0,1,1,8'h00,24'hFFFFFF, 1,1,8'h42,8'h04,3'b000,1,RD1);
    add(0,1,0,1,0,8'h00,24'hFFFFFF, 0,1,8'h42,8'h04,3'b000,1,RD1);
    add(0,1,0,1,1,8'h00,24'hFFFFFF, 1,1,8'h43,8'h03,3'b000,1,RD1);
    add(0,0,0,1,0,8'h00,24'hFFFFFF, 0,1,8'h43,8'h03,3'b000,1,RD1);
    add(0,0,0,1,1,8'hEE,24'hFFFFFF, 0,0,8'h00,8'h00,3'b010,1,RD1);
    add(0,0,0,0,0,8'h00,0, 0,0,8'h00,8'h00,3'b000,0,RD1);
    // init burst wins over simultaneous esc/lee
    add(1,1,1,0,0,8'h00,0, 1,1,8'h02,8'h10,3'b000,1,RD1);
    add(1,0,0,0,0,8'h00,0, 0,1,8'h02,8'h10,3'b000,1,RD1);
    add(1,0,0,0,1,8'h00,0, 1,1,8'h00,8'hD2,3'b000,1,RD1);
    add(0,0,0,0,0,8'h00,0, 0,1,8'h00,8'hD2,3'b000,1,RD1);
    add(0,0,0,0,1,8'h00,0, 1,1,8'h10,8'h00,3'b000,1,RD1);
    add(0,0,0,0,0,8'h00,0, 0,1,8'h10,8'h00,3'b000,1,RD1);
    add(0,0,0,0,1,8'h00,0, 0,0,8'h00,8'h00,3'b100,1,RD1);
    add(0,0,0,0,0,8'h00,0, 0,0,8'h00,8'h00,3'b000,0,RD1);

    repeat (2) @(negedge clk);
    chk("reset_outputs", {17'd0, err, obs()}, 64'd0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      req_init = vecs[i].ri; req_esc = vecs[i].re; req_lee = vecs[i].rl;
      clk_timer = vecs[i].ct; tx_done = vecs[i].done; tx_rdata = vecs[i].rdata;
      {dato_hora, dato_min, dato_seg} = vecs[i].din;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {18'd0, obs()},
          {18'd0, vecs[i].e_start, vecs[i].e_wr, vecs[i].e_dir, vecs[i].e_dato,
           vecs[i].e_ack, vecs[i].e_oc, vecs[i].e_rd});
    end
    chk("err_after_vectors", {63'd0, err}, 64'd0);

    // three simultaneous requests held until acked: init, esc, lee back-to-back
    tx_done = 1'b0; tx_rdata = 8'h5A; clk_timer = 1'b1;
    {dato_hora, dato_min, dato_seg} = 24'h112233;
    req_init = 1'b1; req_esc = 1'b1; req_lee = 1'b1;
    prev_start = 1'b0; nack = 0;
    for (int c = 0; c < 200 && nack < 3; c++) begin
      @(negedge clk);
      if (ack_init || ack_esc || ack_lee) begin
        order[nack] = ack_init ? 0 : (ack_esc ? 1 : 2);
        cyc[nack] = c;
        nack++;
      end
      tx_done = prev_start;
      prev_start = tx_start;
      if (ack_init) req_init = 1'b0;
      if (ack_esc)  req_esc  = 1'b0;
      if (ack_lee)  req_lee  = 1'b0;
    end
    tx_done = 1'b0;
    chk("prio_ack_count", 64'(nack), 64'd3);
    if (nack == 3) begin
      chk("prio_order", {order[0][7:0], order[1][7:0], order[2][7:0]}, 64'h000102);
      chk("prio_first_ack_cycle", 64'(cyc[0]), 64'd6);
      chk("prio_gap_init_esc", 64'(cyc[1] - cyc[0]), 64'd8);
      chk("prio_gap_esc_lee", 64'(cyc[2] - cyc[1]), 64'd8);
    end
    @(negedge clk);
    chk("prio_rd_after_lee", {rd_seg, rd_min, rd_hora}, 64'h5A5A5A);
    chk("prio_idle", {63'd0, ocupado}, 64'd0);

    // engine never answers
    clk_timer = 1'b0; req_lee = 1'b1;
    @(negedge clk);
    req_lee = 1'b0;
    @(negedge clk);
    n = 0;
`ifdef RTC_TIMEOUT_EN
    while (!ack_lee && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_latency", 64'(n), 64'd255);
    chk("timeout_err", {63'd0, err}, 64'd1);
    @(negedge clk);
    chk("timeout_rd_kept", {rd_seg, rd_min, rd_hora}, 64'h5A5A5A);
    chk("timeout_idle", {62'd0, ocupado, err}, 64'd1);
`else
    bad = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (!ocupado || err || ack_lee) bad = 1'b1;
    end
    chk("no_timeout_stays_busy", {63'd0, bad}, 64'd0);
`endif

    // reset during WAIT of step 1 of a read
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    clk_timer = 1'b1; req_lee = 1'b1;
    @(negedge clk);
    req_lee = 1'b0;
    @(negedge clk);
    tx_done = 1'b1; tx_rdata = 8'h77;
    @(negedge clk);
    tx_done = 1'b0;
    chk("rst_pre_start1", {tx_start, tx_dir}, {1'b1, 8'h22});
    @(negedge clk);
    chk("rst_pre_wait1", {tx_start, ocupado, tx_dir}, {1'b0, 1'b1, 8'h22});
    #2 reset = 1'b0;
    #1 chk("rst_async_outputs", {17'd0, err, obs()}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tx_done = (c == 3);
      @(negedge clk);
      if (ack_init || ack_esc || ack_lee || ocupado || tx_start) bad = 1'b1;
      if ({rd_seg, rd_min, rd_hora} != 24'd0) bad = 1'b1;
    end
    tx_done = 1'b0;
    chk("rst_no_ack_no_rd", {63'd0, bad}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
